// File: rtl/split_streamer.sv
// I2S-to-S/PDIF bridge: deserialises 32-bit I2S words and re-emits the top 24 bits
// as a biphase-mark IEC 60958 stream, one clock per half-cell, 128 clocks per frame.
module split_streamer (
    input  logic pin_i2s_bclk_pll,
    input  logic pin_user_sw,
    input  logic pin_i2s_fclk,
    input  logic pin_i2s_bclk,
    input  logic pin_i2s_data,
    output logic pin_opt1,
    output logic red
);
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    typedef enum logic [1:0] {LS_HUNT, LS_ARMED, LS_LOCKED} lock_state_t;

    logic clk;
    logic rst_n;
    assign clk   = pin_i2s_bclk_pll;
    assign rst_n = pin_user_sw;

    // ---------------- input synchronisers: [0]=bclk, [1]=fclk, [2]=data
    logic [2:0] raw_in;
    logic [2:0] sync_out;
    assign raw_in = {pin_i2s_data, pin_i2s_fclk, pin_i2s_bclk};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic meta_reg;
        logic out_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_reg <= 1'b0;
                out_reg  <= 1'b0;
            end else begin
                meta_reg <= raw_in[gi];
                out_reg  <= meta_reg;
            end
        end
        assign sync_out[gi] = out_reg;
    end

    logic bclk_s, fclk_s, data_s;
    assign bclk_s = sync_out[0];
    assign fclk_s = sync_out[1];
    assign data_s = sync_out[2];

    // ---------------- deserialiser and stream watchdog
    logic        bclk_prev, fclk_prev, fclk_at_rise;
    logic [31:0] shift_reg;
    logic        latch_req, latch_right;
    logic [23:0] left_reg;
    logic [7:0]  idle_cnt;
    logic        bclk_rise, fclk_change, stall, pair_done;

    assign bclk_rise   = bclk_s & ~bclk_prev;
    assign fclk_change = fclk_s ^ fclk_prev;
    assign stall       = (idle_cnt == 8'hFF) & ~fclk_change;
    // The shift register still holds the right word on the cycle the pair completes.
    assign pair_done   = latch_req & latch_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_prev    <= 1'b0;
            fclk_prev    <= 1'b0;
            fclk_at_rise <= 1'b0;
            shift_reg    <= '0;
            latch_req    <= 1'b0;
            latch_right  <= 1'b0;
            left_reg     <= '0;
            idle_cnt     <= '0;
        end else begin
            bclk_prev <= bclk_s;
            fclk_prev <= fclk_s;
            latch_req <= 1'b0;
            if (bclk_rise) begin
                shift_reg    <= {shift_reg[30:0], data_s};
                fclk_at_rise <= fclk_s;
                if (fclk_s != fclk_at_rise) begin
                    latch_req   <= 1'b1;
                    latch_right <= ~fclk_s;
                end
            end
            if (latch_req && !latch_right) begin
                left_reg <= shift_reg[31:8];
            end
            if (fclk_change) begin
                idle_cnt <= '0;
            end else if (idle_cnt != 8'hFF) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

    // ---------------- framer / BMC encoder
    lock_state_t lock_state;
    logic        red_reg, opt_reg, pol_reg;
    logic [6:0]  slot_cnt;
    logic [7:0]  frame_cnt;
    logic [23:0] pend_l, pend_r, tx_l, tx_r;
    logic        pend_valid;

    logic [23:0] tx_word;
    logic [7:0]  pre;
    logic [5:0]  half_idx;
    logic [4:0]  slot_idx, bit_idx;
    logic        line_pol, data_bit, opt_next;

    always_comb begin
        tx_word  = slot_cnt[6] ? tx_r : tx_l;
        pre      = PRE_M;
        half_idx = slot_cnt[5:0];
        slot_idx = half_idx[5:1];
        bit_idx  = slot_idx - 5'd4;
        line_pol = (half_idx == 6'd0) ? opt_reg : pol_reg;
        data_bit = 1'b0;
        opt_next = opt_reg;
        if (slot_cnt[6]) begin
            pre = PRE_W;
        end else if (frame_cnt == 8'd0) begin
            pre = PRE_B;
        end
        // V, U and C are always zero, so parity only has to cover the audio bits.
        if (slot_idx >= 5'd4 && slot_idx <= 5'd27) begin
            data_bit = tx_word[bit_idx];
        end else if (slot_idx == 5'd31) begin
            data_bit = ^tx_word;
        end
        if (half_idx < 6'd8) begin
            opt_next = pre[~half_idx[2:0]] ^ line_pol;
        end else if (!half_idx[0]) begin
            opt_next = ~opt_reg;
        end else begin
            opt_next = opt_reg ^ data_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= LS_HUNT;
            red_reg    <= 1'b1;
            opt_reg    <= 1'b0;
            pol_reg    <= 1'b0;
            slot_cnt   <= '0;
            frame_cnt  <= '0;
            pend_l     <= '0;
            pend_r     <= '0;
            pend_valid <= 1'b0;
            tx_l       <= '0;
            tx_r       <= '0;
        end else if (stall) begin
            lock_state <= LS_HUNT;
            red_reg    <= 1'b1;
            opt_reg    <= 1'b0;
            slot_cnt   <= '0;
            frame_cnt  <= '0;
            pend_valid <= 1'b0;
        end else begin
            case (lock_state)
                LS_HUNT: begin
                    if (pair_done) lock_state <= LS_ARMED;
                end
                LS_ARMED: begin
                    if (pair_done) begin
                        lock_state <= LS_LOCKED;
                        red_reg    <= 1'b0;
                        slot_cnt   <= '0;
                        frame_cnt  <= '0;
                        pend_l     <= left_reg;
                        pend_r     <= shift_reg[31:8];
                        pend_valid <= 1'b1;
                    end
                end
                LS_LOCKED: begin
                    slot_cnt <= slot_cnt + 7'd1;
                    opt_reg  <= opt_next;
                    if (half_idx == 6'd0) pol_reg <= opt_reg;
                    if (slot_cnt == 7'd127) begin
                        frame_cnt <= (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
                    end
                    if (slot_cnt == 7'd0 && pend_valid) begin
                        tx_l       <= pend_l;
                        tx_r       <= pend_r;
                        pend_valid <= 1'b0;
                    end
                    // A newly arrived pair always wins over the one just consumed.
                    if (pair_done) begin
                        pend_l     <= left_reg;
                        pend_r     <= shift_reg[31:8];
                        pend_valid <= 1'b1;
                    end
                end
                default: lock_state <= LS_HUNT;
            endcase
        end
    end

    assign pin_opt1 = opt_reg;
    assign red      = red_reg;
endmodule

// File: tb/tb_split_streamer.sv
// Bench for split_streamer: drives I2S frames, decodes the S/PDIF line and
// compares decoded subframes against a scoreboard of the pairs sent.
module tb_split_streamer;
    localparam logic [7:0] PAT_B = 8'b1110_1000;
    localparam logic [7:0] PAT_M = 8'b1110_0010;
    localparam logic [7:0] PAT_W = 8'b1110_0100;

    logic clk = 1'b0;
    logic rst_n, fclk, bclk, sdata;
    logic opt, red;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [25:0] sb_q[$];
    int          completions = 0;
    logic [31:0] prev_l = '0;
    logic [31:0] prev_r = '0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    split_streamer dut (
        .pin_i2s_bclk_pll (clk),
        .pin_user_sw      (rst_n),
        .pin_i2s_fclk     (fclk),
        .pin_i2s_bclk     (bclk),
        .pin_i2s_data     (sdata),
        .pin_opt1         (opt),
        .red              (red)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        sb_q.push_back({1'b0, ^l[31:8], l[31:8]});
        sb_q.push_back({1'b1, ^r[31:8], r[31:8]});
    endtask

    // One 64-bclk I2S frame; the first bit of each frame is the previous right LSB.
    task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
        if (fclk) begin
            completions++;
            if (completions >= 2) push_pair(prev_l, prev_r);
        end
        for (int i = 0; i < 64; i++) begin
            fclk = (i >= 32);
            if (i == 0)       sdata = prev_r[0];
            else if (i < 32)  sdata = l[5'(32 - i)];
            else if (i == 32) sdata = l[0];
            else              sdata = r[5'(64 - i)];
            bclk = 1'b0;
            tick();
            bclk = 1'b1;
            tick();
        end
        prev_l = l;
        prev_r = r;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 400 && sb_q.size() != 0; k++) @(posedge clk);
        check_eq(tag, sb_q.size(), 0);
    endtask

    // ---------------- S/PDIF decoder
    logic [8:0]  hist = '0;
    logic [55:0] sf = '0;
    int          coll = 0;
    bit          collecting = 0;
    int          need = 0;
    bit          have_pre = 0;
    bit          last_left = 0;
    int          last_cyc = 0;
    int          left_idx = 0;
    int          n_b = 0;
    int          n_sf = 0;
    logic        cur_right = 1'b0;
    logic        pre_last = 1'b0;

    task automatic on_preamble(input int typ);
        bit is_left;
        is_left = (typ != 3);
        if (have_pre) begin
            check_eq("side_alternates", is_left, !last_left);
            check_eq("preamble_spacing", cyc - last_cyc, 64);
        end else begin
            check_eq("first_left_after_lock", is_left, 1);
        end
        if (is_left) begin
            check_eq("b_block_position", typ == 1, (left_idx % 192) == 0);
            if (typ == 1) n_b++;
            left_idx++;
        end
        have_pre  = 1;
        last_left = is_left;
        last_cyc  = cyc;
        cur_right = !is_left;
    endtask

    task automatic decode_subframe();
        logic [27:0] bits;
        logic        lvl;
        bit          ok;
        logic [25:0] got, exp;
        lvl = pre_last;
        ok  = 1;
        for (int j = 0; j < 28; j++) begin
            if (sf[2*j] == lvl) ok = 0;
            bits[j] = sf[2*j] ^ sf[2*j+1];
            lvl = sf[2*j+1];
        end
        check_eq("bmc_transitions", ok, 1);
        check_eq("vuc_zero", bits[26:24], 0);
        check_eq("even_parity", ^bits, 0);
        got = {cur_right, bits[27], bits[23:0]};
        n_sf++;
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            $display("subframe %0d %s sample=%06h p=%0d expect=%06h", n_sf,
                     cur_right ? "R" : "L", bits[23:0], bits[27], exp[23:0]);
            check_eq("sample", got, exp);
        end else begin
            $display("subframe %0d %s sample=%06h p=%0d (repeat)", n_sf,
                     cur_right ? "R" : "L", bits[23:0], bits[27]);
        end
    endtask

    always @(negedge clk) begin : decoder
        logic [7:0] win;
        int         typ;
        bit         aligned;
        hist = {hist[7:0], opt};
        if (red !== 1'b0) begin
            collecting = 0;
            need       = 0;
            have_pre   = 0;
            left_idx   = 0;
        end else if (collecting) begin
            sf[coll] = opt;
            coll++;
            if (coll == 56) begin
                decode_subframe();
                collecting = 0;
                need       = 8;
            end
        end else begin
            aligned = 0;
            if (need > 0) begin
                need--;
                aligned = (need == 0);
            end
            if (need == 0) begin
                win = hist[7:0];
                typ = 0;
                if (win == (PAT_B ^ {8{hist[8]}}))      typ = 1;
                else if (win == (PAT_M ^ {8{hist[8]}})) typ = 2;
                else if (win == (PAT_W ^ {8{hist[8]}})) typ = 3;
                if (typ != 0) begin
                    on_preamble(typ);
                    collecting = 1;
                    coll       = 0;
                    pre_last   = hist[0];
                end else if (aligned) begin
                    check_eq("preamble_present", 0, 1);
                end
            end
        end
    end

    // ---------------- stimulus
    initial begin
        rst_n = 1'b0;
        fclk  = 1'b0;
        bclk  = 1'b0;
        sdata = 1'b0;
        #90;
        check_eq("reset_red", red, 1);
        check_eq("reset_opt", opt, 0);
        #20;
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            repeat (50) @(posedge clk);
            @(negedge clk);
            check_eq("idle_red", red, 1);
            check_eq("idle_opt", opt, 0);
        end
        tick();

        send_frame(32'h0, 32'h0);
        check_eq("red_before_lock_f0", red, 1);
        send_frame(32'h0, 32'h0);
        check_eq("red_before_lock_f1", red, 1);
        send_frame(32'h8000_0000, 32'hFFFF_FF00);
        check_eq("red_locked", red, 0);
        repeat (3) send_frame(32'h0, 32'h0);
        for (int k = 0; k < 400; k++) send_frame($urandom, $urandom);
        bclk  = 1'b0;
        sdata = 1'b0;
        check_eq("red_streaming", red, 0);
        wait_drain("drain_run1");

        repeat (300) @(posedge clk);
        @(negedge clk);
        check_eq("stall_red", red, 1);
        check_eq("stall_opt", opt, 0);
        check_eq("b_preambles_seen", n_b, 3);
        tick();

        completions = 0;
        send_frame($urandom, $urandom);
        check_eq("red_discard_after_stall", red, 1);
        send_frame($urandom, $urandom);
        check_eq("relock", red, 0);
        repeat (4) send_frame($urandom, $urandom);
        bclk = 1'b0;
        wait_drain("drain_run2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
